// File: rtl/spi_txn_sequencer_if.sv
// spi_txn_sequencer_if
//   Signal bundle between the host, spi_txn_sequencer and the SPI controller.
//   Host TX push : wr_valid, wr_data, wr_ready
//   Control      : start, len, busy, done, err
//   Host RX pop  : rd_valid, rd_data, rd_ready
//   Controller   : ctrl_tx_count, ctrl_tx_byte, ctrl_tx_dv, ctrl_tx_ready,
//                  ctrl_rx_dv, ctrl_rx_byte, ctrl_rx_count
//   Modports: slave  = sequencer view
//             master = host + controller view
interface spi_txn_sequencer_if #(
   parameter int MAX_BYTES_PER_CS = 2
) ();
   localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);

   logic          wr_valid;
   logic [7:0]    wr_data;
   logic          wr_ready;
   logic          start;
   logic [CW-1:0] len;
   logic          busy;
   logic          done;
   logic          err;
   logic          rd_valid;
   logic [7:0]    rd_data;
   logic          rd_ready;
   logic [CW-1:0] ctrl_tx_count;
   logic [7:0]    ctrl_tx_byte;
   logic          ctrl_tx_dv;
   logic          ctrl_tx_ready;
   logic          ctrl_rx_dv;
   logic [7:0]    ctrl_rx_byte;
   logic [CW-1:0] ctrl_rx_count;

   modport slave (
      input  wr_valid, wr_data, start, len, rd_ready,
             ctrl_tx_ready, ctrl_rx_dv, ctrl_rx_byte, ctrl_rx_count,
      output wr_ready, busy, done, err, rd_valid, rd_data,
             ctrl_tx_count, ctrl_tx_byte, ctrl_tx_dv
   );

   modport master (
      output wr_valid, wr_data, start, len, rd_ready,
             ctrl_tx_ready, ctrl_rx_dv, ctrl_rx_byte, ctrl_rx_count,
      input  wr_ready, busy, done, err, rd_valid, rd_data,
             ctrl_tx_count, ctrl_tx_byte, ctrl_tx_dv
   );
endinterface

// File: rtl/spi_txn_sequencer.sv
// spi_txn_sequencer
//   Buffers host TX bytes, runs a multi-byte chip-select transaction on a
//   single start pulse by driving the controller tx_count/tx_byte/tx_dv
//   handshake byte by byte, and collects every received byte into an RX FIFO.
//   Ports:
//     clk  - single clock shared with the SPI controller
//     rst  - asynchronous active-high reset
//     bus  - spi_txn_sequencer_if.slave (host push/pop, start/len,
//            busy/done/err, controller handshake)
//   Optional build macro:
//     SPI_SEQ_RX_COUNT_CHECK_EN - compare ctrl_rx_count with the byte index on
//     every received byte and pulse err on mismatch.
module spi_txn_sequencer #(
   parameter int MAX_BYTES_PER_CS = 2,
   parameter int FIFO_DEPTH       = 8
) (
   input logic                clk,
   input logic                rst,
   spi_txn_sequencer_if.slave bus
);
   localparam int CW = $clog2(MAX_BYTES_PER_CS + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;                 // pointer width incl. wrap bit
   localparam int XW = (PW > CW) ? PW : CW;    // common width for accept compares
   localparam logic [XW-1:0] MAX_LEN_X = XW'(MAX_BYTES_PER_CS);
   localparam logic [XW-1:0] DEPTH_X   = XW'(FIFO_DEPTH);
   localparam logic [PW-1:0] DEPTH_P   = PW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, WAIT_RDY, SEND, WAIT_RX, FINISH} state_e;
   state_e state_q, state_d;

   logic [7:0]    tx_mem_q [FIFO_DEPTH];
   logic [7:0]    rx_mem_q [FIFO_DEPTH];
   logic [PW-1:0] tx_wr_q, tx_rd_q, tx_occ;
   logic [PW-1:0] rx_wr_q, rx_rd_q, rx_occ;
   logic          tx_full, tx_push, tx_pop;
   logic          rx_empty, rx_push, rx_pop;

   logic [CW-1:0] len_q, len_d, idx_q, idx_d;
   logic [7:0]    tx_byte_q, tx_byte_d;
   logic          err_q, err_d;
   logic          accept, reject, count_bad;
   logic [XW-1:0] len_x, tx_occ_x, rx_free_x;

   // Occupancy wraps modulo 2*FIFO_DEPTH through the pointer width.
   assign tx_occ   = tx_wr_q - tx_rd_q;
   assign rx_occ   = rx_wr_q - rx_rd_q;
   assign tx_full  = (tx_occ == DEPTH_P);
   assign rx_empty = (rx_occ == '0);

   // A push while full is dropped even if the sequencer pops in the same cycle.
   assign tx_push = bus.wr_valid && !tx_full;
   assign tx_pop  = (state_q == WAIT_RDY) && bus.ctrl_tx_ready;
   // RX space is reserved at accept, so the push never overflows.
   assign rx_push = (state_q == WAIT_RX) && bus.ctrl_rx_dv;
   assign rx_pop  = bus.rd_ready && !rx_empty;

   assign len_x     = XW'(bus.len);
   assign tx_occ_x  = XW'(tx_occ);
   assign rx_free_x = DEPTH_X - XW'(rx_occ);

   assign accept = (state_q == IDLE) && bus.start &&
                   (len_x != '0) && (len_x <= MAX_LEN_X) &&
                   (tx_occ_x >= len_x) && (rx_free_x >= len_x);
   assign reject = (state_q == IDLE) && bus.start && !accept;

`ifdef SPI_SEQ_RX_COUNT_CHECK_EN
   assign count_bad = rx_push && (bus.ctrl_rx_count != idx_q);
`else
   logic unused_rx_count;
   assign unused_rx_count = ^bus.ctrl_rx_count;
   assign count_bad       = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      tx_byte_d = tx_byte_q;
      err_d     = reject || count_bad;
      case (state_q)
         IDLE: begin
            if (accept) begin
               len_d   = bus.len;
               idx_d   = '0;
               state_d = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (bus.ctrl_tx_ready) begin
               tx_byte_d = tx_mem_q[tx_rd_q[AW-1:0]];
               state_d   = SEND;
            end
         end
         SEND: state_d = WAIT_RX;
         WAIT_RX: begin
            if (bus.ctrl_rx_dv) begin
               idx_d   = idx_q + CW'(1);
               state_d = (idx_q == len_q - CW'(1)) ? FINISH : WAIT_RDY;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q     <= '0;
         idx_q     <= '0;
         tx_byte_q <= '0;
         err_q     <= 1'b0;
         tx_wr_q   <= '0;
         tx_rd_q   <= '0;
         rx_wr_q   <= '0;
         rx_rd_q   <= '0;
      end else begin
         len_q     <= len_d;
         idx_q     <= idx_d;
         tx_byte_q <= tx_byte_d;
         err_q     <= err_d;
         if (tx_push) tx_wr_q <= tx_wr_q + PW'(1);
         if (tx_pop)  tx_rd_q <= tx_rd_q + PW'(1);
         if (rx_push) rx_wr_q <= rx_wr_q + PW'(1);
         if (rx_pop)  rx_rd_q <= rx_rd_q + PW'(1);
      end
   end

   // Storage needs no reset: pointers define validity.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wr_q[AW-1:0]] <= bus.wr_data;
      if (rx_push) rx_mem_q[rx_wr_q[AW-1:0]] <= bus.ctrl_rx_byte;
   end

   assign bus.wr_ready      = !tx_full;
   assign bus.busy          = (state_q != IDLE);
   assign bus.done          = (state_q == FINISH);
   assign bus.err           = err_q;
   assign bus.ctrl_tx_dv    = (state_q == SEND);
   assign bus.ctrl_tx_count = len_q;
   assign bus.ctrl_tx_byte  = tx_byte_q;
   assign bus.rd_valid      = !rx_empty;
   // Head is masked while empty so unwritten storage never shows after reset.
   assign bus.rd_data       = rx_empty ? '0 : rx_mem_q[rx_rd_q[AW-1:0]];
endmodule

// File: tb/tb_spi_txn_sequencer.sv
`timescale 1ns/1ps
module tb_spi_txn_sequencer;
   localparam int MAXB  = 2;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(MAXB + 1);
   localparam int RVW   = 6 + CW + 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   spi_txn_sequencer_if #(.MAX_BYTES_PER_CS(MAXB)) bus ();
   spi_txn_sequencer #(.MAX_BYTES_PER_CS(MAXB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: plain queues of FIFO contents.
   logic [7:0] tx_model[$];
   logic [7:0] rx_model[$];
   logic [7:0] exp_tx_q[$];
   int         exp_cnt_q[$];
   logic [7:0] rx_fixed[$];

   // Monitor
   logic [7:0]  mon_byte_q[$];
   int          mon_cnt_q[$];
   int          done_total = 0, err_total = 0, busy_cycles = 0;
   int unsigned last_done_cyc = 0, last_err_cyc = 0, last_fall_cyc = 0;
   bit          prev_busy = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (bus.ctrl_tx_dv === 1'b1) begin
               mon_byte_q.push_back(bus.ctrl_tx_byte);
               mon_cnt_q.push_back(int'(bus.ctrl_tx_count));
            end
            if (bus.done === 1'b1) begin done_total++; last_done_cyc = cyc; end
            if (bus.err === 1'b1) begin err_total++; last_err_cyc = cyc; end
            if (bus.busy === 1'b1) busy_cycles++;
            if (prev_busy && bus.busy === 1'b0) last_fall_cyc = cyc;
         end
         prev_busy = (bus.busy === 1'b1);
      end
   end

   // Controller model: answers each tx_dv with one rx_dv after a short delay.
   logic [7:0]  rx_plan[$];
   int          resp_wait = -1, resp_idx = 0, resp_len = 1;
   bit          rand_ready = 0, resp_hold = 0, bad_count_once = 0;
   int unsigned last_rxdv_cyc = 0, bad_rxdv_cyc = 0;
   initial begin
      bus.ctrl_tx_ready = 1'b0;
      bus.ctrl_rx_dv    = 1'b0;
      bus.ctrl_rx_byte  = 8'h00;
      bus.ctrl_rx_count = '0;
      forever begin
         @(negedge clk);
         bus.ctrl_rx_dv = 1'b0;
         if (rst) begin
            resp_wait = -1;
            resp_idx  = 0;
            bus.ctrl_tx_ready = 1'b0;
         end else begin
            bus.ctrl_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (resp_wait == 0 && !resp_hold) begin
               bus.ctrl_rx_dv = 1'b1;
               if (rx_plan.size() > 0) bus.ctrl_rx_byte = rx_plan.pop_front();
               else                    bus.ctrl_rx_byte = 8'($urandom);
               bus.ctrl_rx_count = CW'(resp_idx);
               if (bad_count_once) begin
                  bus.ctrl_rx_count = CW'(resp_idx + 1);
                  bad_count_once = 0;
                  bad_rxdv_cyc = cyc;
               end
               last_rxdv_cyc = cyc;
               resp_idx  = (resp_idx + 1 >= resp_len) ? 0 : resp_idx + 1;
               resp_wait = -1;
            end else if (resp_wait > 0 && !resp_hold) begin
               resp_wait--;
            end
            if (bus.ctrl_tx_dv === 1'b1) begin
               resp_len  = int'(bus.ctrl_tx_count);
               resp_wait = int'($urandom_range(0, 2));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- host drivers (no checking) ----------------
   task automatic push_byte(input logic [7:0] b);
      @(negedge clk);
      if (tx_model.size() < DEPTH) tx_model.push_back(b);
      bus.wr_valid = 1'b1;
      bus.wr_data  = b;
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic pop_byte(output logic [7:0] b, output logic v);
      @(negedge clk);
      v = bus.rd_valid;
      b = bus.rd_data;
      bus.rd_ready = 1'b1;
      @(negedge clk);
      bus.rd_ready = 1'b0;
   endtask

   task automatic start_txn(input int l);
      @(negedge clk);
      bus.start = 1'b1;
      bus.len   = CW'(l);
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(output bit to);
      int k;
      k = 0;
      while (bus.busy === 1'b1 && k < 300) begin @(negedge clk); k++; end
      to = (k >= 300);
   endtask

   function automatic bit model_accepts(input int l);
      return (l >= 1) && (l <= MAXB) && (tx_model.size() >= l) &&
             ((DEPTH - rx_model.size()) >= l);
   endfunction

   task automatic run_txn(input int l, output bit acc, output bit to);
      logic [7:0] r;
      acc = model_accepts(l);
      if (acc) begin
         for (int i = 0; i < l; i++) begin
            r = 8'($urandom);
            if (rx_fixed.size() > 0) r = rx_fixed.pop_front();
            exp_tx_q.push_back(tx_model.pop_front());
            exp_cnt_q.push_back(l);
            rx_plan.push_back(r);
            rx_model.push_back(r);
         end
      end
      start_txn(l);
      wait_idle(to);
   endtask

   task automatic clear_mon();
      mon_byte_q.delete(); mon_cnt_q.delete();
      exp_tx_q.delete();   exp_cnt_q.delete();
   endtask

   function automatic logic [RVW-1:0] obs_vec();
      return {bus.wr_ready, bus.busy, bus.done, bus.err, bus.rd_valid, bus.ctrl_tx_dv,
              bus.ctrl_tx_count, bus.ctrl_tx_byte, bus.rd_data};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [RVW-1:0] exp;
      exp = {1'b1, 5'b00000, CW'(0), 8'h00, 8'h00};
      n_cmp++; if (obs_vec() !== exp) begin n_bad++;
         $display("FAIL reset_state: got %h expected %h", obs_vec(), exp); end
   endtask

   task automatic test_single_byte();
      int d0, e0; bit acc, to; logic [7:0] b; logic v;
      clear_mon(); d0 = done_total; e0 = err_total;
      push_byte(8'hA5);
      rx_fixed.push_back(8'h3C);
      run_txn(1, acc, to);
      n_cmp++; if (to) begin n_bad++; $display("FAIL single_timeout: busy=%b expected 0", bus.busy); end
      n_cmp++; if (mon_byte_q.size() != 1 || mon_byte_q[0] !== 8'hA5 || mon_cnt_q[0] != 1) begin n_bad++;
         $display("FAIL single_tx: got %0d pulses first byte %h count %0d expected 1 pulse a5 count 1",
                  mon_byte_q.size(), mon_byte_q.size() ? mon_byte_q[0] : 8'h00, mon_cnt_q.size() ? mon_cnt_q[0] : -1); end
      n_cmp++; if (done_total - d0 != 1) begin n_bad++;
         $display("FAIL single_done: got %0d expected 1", done_total - d0); end
      n_cmp++; if (err_total != e0) begin n_bad++;
         $display("FAIL single_err: got %0d expected 0", err_total - e0); end
      n_cmp++; if (last_done_cyc - last_rxdv_cyc != 1 || last_fall_cyc - last_rxdv_cyc != 2) begin n_bad++;
         $display("FAIL single_timing: done+%0d busy_low+%0d expected +1 +2",
                  last_done_cyc - last_rxdv_cyc, last_fall_cyc - last_rxdv_cyc); end
      n_cmp++; if ({bus.rd_valid, bus.rd_data} !== {1'b1, 8'h3C}) begin n_bad++;
         $display("FAIL single_rd: got %b/%h expected 1/3c", bus.rd_valid, bus.rd_data); end
      pop_byte(b, v); void'(rx_model.pop_front());
      n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++;
         $display("FAIL single_drain: rd_valid=%b expected 0", bus.rd_valid); end
   endtask

   task automatic test_two_byte();
      int d0; bit acc, to; logic [7:0] b; logic v;
      clear_mon(); d0 = done_total;
      push_byte(8'h9F); push_byte(8'h00);
      rx_fixed.push_back(8'h11); rx_fixed.push_back(8'hEF);
      run_txn(2, acc, to);
      n_cmp++; if (to || mon_byte_q.size() != 2) begin n_bad++;
         $display("FAIL two_pulses: got %0d timeout=%b expected 2", mon_byte_q.size(), to); end
      else begin
         n_cmp++; if ({mon_byte_q[0], mon_byte_q[1]} !== 16'h9F00 || mon_cnt_q[0] != 2 || mon_cnt_q[1] != 2) begin n_bad++;
            $display("FAIL two_tx: got %h %h cnt %0d %0d expected 9f 00 cnt 2 2",
                     mon_byte_q[0], mon_byte_q[1], mon_cnt_q[0], mon_cnt_q[1]); end
      end
      n_cmp++; if (done_total - d0 != 1) begin n_bad++;
         $display("FAIL two_done: got %0d expected 1", done_total - d0); end
      pop_byte(b, v); void'(rx_model.pop_front());
      n_cmp++; if ({v, b} !== {1'b1, 8'h11}) begin n_bad++; $display("FAIL two_rx0: got %b/%h expected 1/11", v, b); end
      pop_byte(b, v); void'(rx_model.pop_front());
      n_cmp++; if ({v, b} !== {1'b1, 8'hEF}) begin n_bad++; $display("FAIL two_rx1: got %b/%h expected 1/ef", v, b); end
   endtask

   task automatic test_rejects();
      int e0, b0, d0; bit acc, to; logic [7:0] b; logic v;
      clear_mon(); e0 = err_total; b0 = busy_cycles; d0 = done_total;
      push_byte(8'h42);
      run_txn(0, acc, to);
      run_txn(3, acc, to);
      run_txn(2, acc, to);
      n_cmp++; if (err_total - e0 != 3) begin n_bad++;
         $display("FAIL reject_err: got %0d pulses expected 3", err_total - e0); end
      n_cmp++; if (busy_cycles != b0 || mon_byte_q.size() != 0 || done_total != d0) begin n_bad++;
         $display("FAIL reject_busy: busy cycles %0d tx pulses %0d expected 0 0", busy_cycles - b0, mon_byte_q.size()); end
      n_cmp++; if ({bus.wr_ready, bus.rd_valid} !== 2'b10) begin n_bad++;
         $display("FAIL reject_fifo: wr_ready/rd_valid %b%b expected 10", bus.wr_ready, bus.rd_valid); end
      run_txn(1, acc, to);
      n_cmp++; if (mon_byte_q.size() != 1 || mon_byte_q[0] !== 8'h42) begin n_bad++;
         $display("FAIL reject_keep: got %0d pulses expected one with 42", mon_byte_q.size()); end
      pop_byte(b, v); void'(rx_model.pop_front());
   endtask

   task automatic test_fifo_bounds();
      int e0, d0; bit acc, to; logic [7:0] b, e; logic v;
      clear_mon();
      for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom));
      n_cmp++; if (bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL fifo_full: wr_ready=%b expected 0", bus.wr_ready); end
      push_byte(8'hEE);   // dropped by DUT and model alike
      n_cmp++; if (bus.wr_ready !== 1'b0) begin n_bad++; $display("FAIL fifo_full2: wr_ready=%b expected 0", bus.wr_ready); end
      for (int i = 0; i < 3; i++) run_txn(2, acc, to);
      run_txn(1, acc, to);
      push_byte(8'($urandom)); push_byte(8'($urandom));
      e0 = err_total; d0 = done_total;
      run_txn(2, acc, to);   // RX at 7/8: rejected
      n_cmp++; if (err_total - e0 != 1 || done_total != d0) begin n_bad++;
         $display("FAIL fifo_rxspace: err %0d done %0d expected 1 0", err_total - e0, done_total - d0); end
      pop_byte(b, v); e = rx_model.pop_front();
      n_cmp++; if ({v, b} !== {1'b1, e}) begin n_bad++; $display("FAIL fifo_pop: got %b/%h expected 1/%h", v, b, e); end
      e0 = err_total; d0 = done_total;
      run_txn(2, acc, to);
      n_cmp++; if (err_total != e0 || done_total - d0 != 1 || to) begin n_bad++;
         $display("FAIL fifo_retry: err %0d done %0d expected 0 1", err_total - e0, done_total - d0); end
      n_cmp++; if (mon_byte_q.size() != exp_tx_q.size()) begin n_bad++;
         $display("FAIL fifo_txlen: got %0d expected %0d", mon_byte_q.size(), exp_tx_q.size()); end
      else foreach (exp_tx_q[i]) begin
         n_cmp++; if (mon_byte_q[i] !== exp_tx_q[i] || mon_cnt_q[i] != exp_cnt_q[i]) begin n_bad++;
            $display("FAIL fifo_tx%0d: got %h/%0d expected %h/%0d", i, mon_byte_q[i], mon_cnt_q[i], exp_tx_q[i], exp_cnt_q[i]); end
      end
      while (rx_model.size() > 0) begin
         pop_byte(b, v); e = rx_model.pop_front();
         n_cmp++; if ({v, b} !== {1'b1, e}) begin n_bad++; $display("FAIL fifo_rx: got %b/%h expected 1/%h", v, b, e); end
      end
      run_txn(1, acc, to);
      pop_byte(b, v); void'(rx_model.pop_front());
   endtask

   task automatic test_back_to_back();
      int d0, e0, k; bit to; logic [7:0] b; logic v;
      clear_mon(); d0 = done_total; e0 = err_total;
      push_byte(8'h5C); push_byte(8'hC5);
      rx_plan.push_back(8'h01); rx_plan.push_back(8'h02);
      void'(tx_model.pop_front()); void'(tx_model.pop_front());
      rx_model.push_back(8'h01); rx_model.push_back(8'h02);
      start_txn(1);
      k = 0;
      while (bus.done !== 1'b1 && k < 100) begin @(negedge clk); k++; end
      bus.start = 1'b1;   // held through the done cycle and the next one
      bus.len   = CW'(1);
      @(negedge clk);
      n_cmp++; if ({bus.busy, bus.err} !== 2'b00) begin n_bad++;
         $display("FAIL b2b_done_cycle: busy/err %b%b expected 00", bus.busy, bus.err); end
      @(negedge clk);
      bus.start = 1'b0;
      n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: busy=%b expected 1", bus.busy); end
      wait_idle(to);
      n_cmp++; if (done_total - d0 != 2 || err_total != e0 || to) begin n_bad++;
         $display("FAIL b2b_count: done %0d err %0d expected 2 0", done_total - d0, err_total - e0); end
      n_cmp++; if (mon_byte_q.size() != 2 || {mon_byte_q[0], mon_byte_q[1]} !== 16'h5CC5) begin n_bad++;
         $display("FAIL b2b_tx: got %0d pulses expected 5c then c5", mon_byte_q.size()); end
      for (int i = 1; i <= 2; i++) begin
         pop_byte(b, v); void'(rx_model.pop_front());
         n_cmp++; if ({v, b} !== {1'b1, 8'(i)}) begin n_bad++; $display("FAIL b2b_rx: got %b/%h expected 1/%h", v, b, 8'(i)); end
      end
   endtask

   task automatic test_count_check();
      int d0, e0; bit acc, to; logic [7:0] b; logic v;
      clear_mon(); d0 = done_total; e0 = err_total;
      push_byte(8'h33); push_byte(8'h44);
      rx_fixed.push_back(8'hAA); rx_fixed.push_back(8'hBB);
      bad_count_once = 1;
      run_txn(2, acc, to);
`ifdef SPI_SEQ_RX_COUNT_CHECK_EN
      n_cmp++; if (err_total - e0 != 1 || last_err_cyc - bad_rxdv_cyc != 1) begin n_bad++;
         $display("FAIL cnt_err: got %0d pulses at +%0d expected 1 at +1", err_total - e0, last_err_cyc - bad_rxdv_cyc); end
`else
      n_cmp++; if (err_total != e0) begin n_bad++;
         $display("FAIL cnt_err: got %0d pulses expected 0", err_total - e0); end
`endif
      n_cmp++; if (done_total - d0 != 1 || to) begin n_bad++;
         $display("FAIL cnt_done: got %0d expected 1", done_total - d0); end
      pop_byte(b, v); void'(rx_model.pop_front());
      n_cmp++; if ({v, b} !== {1'b1, 8'hAA}) begin n_bad++; $display("FAIL cnt_rx0: got %b/%h expected 1/aa", v, b); end
      pop_byte(b, v); void'(rx_model.pop_front());
      n_cmp++; if ({v, b} !== {1'b1, 8'hBB}) begin n_bad++; $display("FAIL cnt_rx1: got %b/%h expected 1/bb", v, b); end
   endtask

   task automatic test_mid_reset();
      int k, d0; bit acc, to; logic [7:0] b; logic v; logic [RVW-1:0] exp;
      clear_mon();
      push_byte(8'h10);
      run_txn(1, acc, to);          // leaves one byte in RX
      push_byte(8'h20); push_byte(8'h30);
      resp_hold = 1;
      start_txn(2);
      k = 0;
      while (bus.ctrl_tx_dv !== 1'b1 && k < 50) begin @(negedge clk); k++; end
      @(negedge clk);               // now waiting for byte 0 response
      n_cmp++; if ({bus.busy, bus.rd_valid, bus.ctrl_tx_count} !== {2'b11, CW'(2)}) begin n_bad++;
         $display("FAIL mreset_pre: busy/rd_valid/count %b%b/%0d expected 11/2", bus.busy, bus.rd_valid, bus.ctrl_tx_count); end
      #1 rst = 1'b1;
      #1;
      exp = {1'b1, 5'b00000, CW'(0), 8'h00, 8'h00};
      n_cmp++; if (obs_vec() !== exp) begin n_bad++;
         $display("FAIL mreset_async: got %h expected %h", obs_vec(), exp); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      resp_hold = 0;
      tx_model.delete(); rx_model.delete(); rx_plan.delete(); rx_fixed.delete();
      clear_mon(); d0 = done_total;
      push_byte(8'h5A);
      rx_fixed.push_back(8'h77);
      run_txn(1, acc, to);
      n_cmp++; if (done_total - d0 != 1 || mon_byte_q.size() != 1 || mon_byte_q[0] !== 8'h5A) begin n_bad++;
         $display("FAIL mreset_after: done %0d pulses %0d expected 1 1 (byte 5a)", done_total - d0, mon_byte_q.size()); end
      pop_byte(b, v); void'(rx_model.pop_front());
      n_cmp++; if ({v, b} !== {1'b1, 8'h77}) begin n_bad++; $display("FAIL mreset_rx: got %b/%h expected 1/77", v, b); end
   endtask

   task automatic test_random();
      int op, l, e0, d0; bit acc, to; logic [7:0] b, e; logic v;
      clear_mon();
      rand_ready = 1;
      for (int it = 0; it < 80; it++) begin
         op = int'($urandom_range(0, 9));
         if (op <= 3) begin
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) push_byte(8'($urandom));
            n_cmp++; if (bus.wr_ready !== (tx_model.size() < DEPTH)) begin n_bad++;
               $display("FAIL rnd_wr_ready: got %b expected %b", bus.wr_ready, tx_model.size() < DEPTH); end
         end else if (op <= 7) begin
            l = int'($urandom_range(0, 3));
            e0 = err_total; d0 = done_total;
            run_txn(l, acc, to);
            n_cmp++; if (to || err_total - e0 != int'(!acc) || done_total - d0 != int'(acc)) begin n_bad++;
               $display("FAIL rnd_txn len %0d: err %0d done %0d timeout %b expected %0d %0d 0",
                        l, err_total - e0, done_total - d0, to, !acc, acc); end
         end else begin
            pop_byte(b, v);
            if (rx_model.size() > 0) begin
               e = rx_model.pop_front();
               n_cmp++; if ({v, b} !== {1'b1, e}) begin n_bad++; $display("FAIL rnd_pop: got %b/%h expected 1/%h", v, b, e); end
            end else begin
               n_cmp++; if (v !== 1'b0) begin n_bad++; $display("FAIL rnd_pop_empty: rd_valid=%b expected 0", v); end
            end
         end
      end
      n_cmp++; if (mon_byte_q.size() != exp_tx_q.size()) begin n_bad++;
         $display("FAIL rnd_txlen: got %0d expected %0d", mon_byte_q.size(), exp_tx_q.size()); end
      else foreach (exp_tx_q[i]) begin
         n_cmp++; if (mon_byte_q[i] !== exp_tx_q[i] || mon_cnt_q[i] != exp_cnt_q[i]) begin n_bad++;
            $display("FAIL rnd_tx%0d: got %h/%0d expected %h/%0d", i, mon_byte_q[i], mon_cnt_q[i], exp_tx_q[i], exp_cnt_q[i]); end
      end
      while (rx_model.size() > 0) begin
         pop_byte(b, v); e = rx_model.pop_front();
         n_cmp++; if ({v, b} !== {1'b1, e}) begin n_bad++; $display("FAIL rnd_drain: got %b/%h expected 1/%h", v, b, e); end
      end
      rand_ready = 0;
   endtask

   initial begin
      bus.wr_valid = 1'b0; bus.wr_data = 8'h00;
      bus.start = 1'b0;    bus.len = '0;
      bus.rd_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_byte();
      test_two_byte();
      test_rejects();
      test_fifo_bounds();
      test_back_to_back();
      test_count_check();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
